uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Byte-to-serial UART transmitter, 8N1 by default, LSB first, with a programmable bit period.
- Sits directly upstream of the UART receive/decode stage and drives that stage's serial data input.
- Accepts bytes from a command or test source over a valid/ready handshake.
- Used on-chip for loopback and to drive the board TX pin.

Parameters:
- CLKS_PER_BIT, 434, i_clk cycles per serial bit (50 MHz / 115200). Legal range is 2 to 65535.
- STOP_BITS, 1, number of stop bits. Legal values are 1 or 2.

Ports:
- i_clk  input  1  system clock; all logic is rising-edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_data  input  8  byte to transmit; sampled only on handshake.
- i_valid  input  1  source has a byte on i_data.
- o_ready  output  1  serializer can accept a byte this cycle.
- o_txd  output  1  serial line; idle high.
- o_busy  output  1  frame in progress.
- o_done  output  1  single-cycle pulse at end of last stop bit.

Behaviour:
- Reset: one clock, i_clk. Reset is asynchronous, active-low on i_rst_n. While asserted:
  - o_txd=1, o_ready=1, o_busy=0, o_done=0.
  - State is IDLE; baud counter, bit index and shift register are 0.
- All outputs are registered; none is combinational from inputs.
- Handshake:
  - A transfer occurs on a rising edge where i_valid=1 and o_ready=1.
  - i_data is latched into the shift register at that edge.
  - o_ready is 1 only in IDLE. It drops in the cycle after acceptance.
  - i_valid/i_data are ignored while o_ready=0. No queuing.
- Baud counter:
  - Width is ceil(log2(CLKS_PER_BIT)).
  - Counts 0 to CLKS_PER_BIT-1, wraps to 0, and produces a bit tick at the terminal count.
  - Counter is cleared on acceptance, so every bit on o_txd lasts exactly CLKS_PER_BIT cycles.
- State machine:
  - IDLE: o_txd=1. On handshake go to START; o_txd=0 from the next cycle (latency 1 clock).
  - START: o_txd=0 for one bit period, then go to DATA with bit index 0.
  - DATA: o_txd=shift[0]. On each bit tick, shift right and increment the index. After the tick with index 7, go to STOP.
  - STOP: o_txd=1 for STOP_BITS bit periods. On the final tick, go to IDLE, pulse o_done for one cycle, and set o_ready=1.
- Frame length is (1+8+STOP_BITS)*CLKS_PER_BIT cycles, measured from the first o_txd=0 cycle to the first IDLE cycle.
- o_busy=1 in every non-IDLE state.
- Back-to-back transfers: a handshake in the cycle o_ready returns high starts the next START bit on the following cycle. The minimum line idle between frames is 1 clock beyond the stop bit(s).
- Simultaneous o_done and new handshake: both are legal. o_done still pulses and the new byte is accepted.
- Reset mid-frame: o_txd returns high immediately (asynchronous) and the partial frame is abandoned. The first handshake after reset release starts a clean frame.
- No error outputs. Out-of-range parameters are a synthesis-time error: generate a failing assertion on illegal values.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - o_txd carries the even-parity bit, the XOR of the 8 latched data bits, for one bit period.
  - Frame becomes (1+8+1+STOP_BITS)*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic synthesized, and the frame is exactly as above.

Test Plan:
- Reset: hold i_rst_n=0 for 5 cycles with i_valid=1 -> o_txd=1, o_ready=1, o_busy=0, o_done=0 throughout; no acceptance.
- Single byte: CLKS_PER_BIT=4, STOP_BITS=1, send 0x47.
  - o_txd, in 4-cycle groups: 0,1,1,1,0,0,0,1,0,1 (40 cycles).
  - o_done pulses once, on the cycle after the stop bit.
  - A loopback into the downstream receiver decodes 0x47.
- Back-to-back: 0x55 then 0xAA with i_valid held high.
  - Second START begins 1 cycle after the first frame's stop bit ends.
  - Exactly two o_done pulses.
  - i_data changes mid-frame have no effect.
- Mid-frame reset: assert i_rst_n=0 during data bit 3 of 0xF0 -> o_txd=1 in the same cycle (asynchronous). After release, 0x0F transmits correctly.
- STOP_BITS=2, CLKS_PER_BIT=2: send 0x00 -> o_txd low for 18 cycles, then high for 4 cycles, then o_done pulses.
- With UART_TX_PARITY_EN, CLKS_PER_BIT=4:
  - 0x47 -> parity bit 0 after bit 7 (44-cycle frame).
  - 0x07 -> parity bit 1.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART transmitter, LSB first, 1 or 2 stop bits; even parity bit when UART_TX_PARITY_EN is defined.
// Start bit appears 1 clk after the handshake; o_ready stays low for the whole frame (no queuing).
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_txd,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
      $error("uart_tx_serializer: CLKS_PER_BIT must be in 2..65535");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          txd_q, ready_q, busy_q, done_q;
  logic          tick;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // o_ready is high in every IDLE cycle, so i_valid alone is the handshake here
          if (i_valid) begin
            state_q <= S_START;
            cnt_q   <= '0;
            shift_q <= i_data;
            txd_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^i_data;
`endif
          end
        end
        S_START: begin
          cnt_q <= cnt_d;
          if (tick) begin
            state_q <= S_DATA;
            idx_q   <= '0;
            txd_q   <= shift_q[0];
          end
        end
        S_DATA: begin
          cnt_q <= cnt_d;
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (idx_q == 3'd7) begin
              idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= par_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
              txd_q <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          cnt_q <= cnt_d;
          if (tick) begin
            state_q <= S_STOP;
            idx_q   <= '0;
            txd_q   <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          cnt_q <= cnt_d;
          if (tick) begin
            if (idx_q == STOP_LAST) begin
              state_q <= S_IDLE;
              idx_q   <= '0;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_txd   = txd_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: queue-based line model checked every cycle, plus hand-computed frame checks.
module tb_uart_tx_serializer;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL  = (1 + 8 + PAR + 1) * CPB;
  localparam int FL2 = (1 + 8 + PAR + 2) * 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0, valid2 = 1'b0;
  logic [7:0] data = 8'h00, data2 = 8'h00;
  logic       txd, ready, busy, done;
  logic       txd2, ready2, busy2, done2;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_txd(txd), .o_busy(busy), .o_done(done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data2), .i_valid(valid2),
    .o_ready(ready2), .o_txd(txd2), .o_busy(busy2), .o_done(done2)
  );

  always #5 clk = ~clk;

  // Model: the queue holds the expected line level for every remaining cycle of the frame.
  bit   mq[$];
  bit   m_idle;
  logic m_txd = 1'b1, m_busy = 1'b0, m_ready = 1'b1, m_done = 1'b0;

  function automatic void push_frame(input logic [7:0] b);
    bit bits[$];
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
    if (PAR != 0) bits.push_back(^b);
    bits.push_back(1'b1);
    foreach (bits[j]) for (int c = 0; c < CPB; c++) mq.push_back(bits[j]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_done = 1'b0;
    end else begin
      m_idle = (mq.size() == 0);
      m_done = 1'b0;
      if (!m_idle) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end else if (valid) begin
        push_frame(data);
      end
    end
    m_busy  = (mq.size() != 0);
    m_txd   = m_busy ? mq[0] : 1'b1;
    m_ready = !m_busy;
  end

  int          total = 0, bad = 0;
  string       lit_name [0:255];
  logic [63:0] lit_act  [0:255];
  logic [63:0] lit_exp  [0:255];
  int          lit_n = 0, lit_rd = 0;

  task automatic post(input string n, input logic [63:0] a, input logic [63:0] e);
    lit_name[lit_n] = n;
    lit_act[lit_n]  = a;
    lit_exp[lit_n]  = e;
    lit_n++;
  endtask

  task automatic chk(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", n, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    chk("model_txd", txd, m_txd);
    chk("model_ready", ready, m_ready);
    chk("model_busy", busy, m_busy);
    chk("model_done", done, m_done);
    while (lit_rd < lit_n) begin
      total++;
      if (lit_act[lit_rd] !== lit_exp[lit_rd]) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      end
      lit_rd++;
    end
  end

  logic capv [0:255];
  logic capd [0:255];
  int   dcnt, lows, highs, d2early;

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1 data = b; valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0;
  endtask

  task automatic capture(input int n);
    dcnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      capv[i] = txd;
      capd[i] = done;
      if (done) dcnt++;
    end
  endtask

  function automatic logic [7:0] dec(input int off);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = capv[off + (1 + k) * CPB + CPB / 2];
    return r;
  endfunction

  logic [15:0] g;
  logic [63:0] av, ev;

  initial begin
    rst_n = 1'b0; valid = 1'b1; data = 8'hA5; valid2 = 1'b1; data2 = 8'h5A;
    repeat (5) begin
      @(negedge clk);
      post("rst_txd", txd, 1); post("rst_ready", ready, 1);
      post("rst_busy", busy, 0); post("rst_done", done, 0);
      post("rst2_ready", ready2, 1);
    end
    @(posedge clk); #1 valid = 1'b0; valid2 = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single byte 0x47: line groups in transmit order, first bit in g[0]
    send(8'h47);
    capture(FL + 1);
`ifdef UART_TX_PARITY_EN
    g = 16'b0000_0100_1000_1110;
`else
    g = 16'b0000_0010_1000_1110;
`endif
    av = '0; ev = '0;
    for (int i = 0; i < FL; i++) begin
      av[i] = capv[i];
      ev[i] = g[i / CPB];
    end
    post("wave_47", av, ev);
    post("loop_47", dec(0), 8'h47);
    post("done_47_pos", capd[FL], 1);
    post("done_47_count", dcnt, 1);
    post("idle_after_47", capv[FL], 1);

    // Back-to-back 0x55 / 0xAA with i_valid held and i_data disturbed mid-frame
    @(posedge clk); #1 data = 8'h55; valid = 1'b1;
    @(posedge clk); #1;
    dcnt = 0;
    for (int i = 0; i < 2 * FL + 3; i++) begin
      @(negedge clk);
      capv[i] = txd;
      capd[i] = done;
      if (done) dcnt++;
      if (i == 5) data = 8'h33;
      if (i == 20) data = 8'hAA;
      if (i == FL) begin
        @(posedge clk); #1 valid = 1'b0; data = 8'hC3;
      end
    end
    post("b2b_byte1", dec(0), 8'h55);
    post("b2b_gap", capv[FL], 1);
    post("b2b_start2", capv[FL + 1], 0);
    post("b2b_byte2", dec(FL + 1), 8'hAA);
    post("b2b_dones", dcnt, 2);
    post("b2b_done2_pos", capd[2 * FL + 1], 1);
    post("b2b_idle_after", capv[2 * FL + 2], 1);

    // Reset during data bit 3 of 0xF0 (a low bit), then a clean 0x0F
    repeat (2) @(posedge clk);
    send(8'hF0);
    for (int i = 0; i < 18; i++) @(negedge clk);
    post("pre_arst_txd", txd, 0);
    #2 rst_n = 1'b0;
    #1 post("arst_txd", txd, 1); post("arst_busy", busy, 0); post("arst_ready", ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send(8'h0F);
    capture(FL + 1);
    post("after_arst_0f", dec(0), 8'h0F);
    post("after_arst_start", capv[0], 0);
    post("after_arst_done", capd[FL], 1);

`ifdef UART_TX_PARITY_EN
    repeat (2) @(posedge clk);
    send(8'h07);
    capture(FL + 1);
    post("parity_07", capv[9 * CPB + CPB / 2], 1);
    post("parity_07_byte", dec(0), 8'h07);
`endif

    // Two stop bits at 2 clocks per bit, byte 0x00
    @(posedge clk); #1 data2 = 8'h00; valid2 = 1'b1;
    @(posedge clk); #1 valid2 = 1'b0;
    lows = 0; highs = 0; d2early = 0;
    for (int i = 0; i < FL2 + 1; i++) begin
      @(negedge clk);
      if (i < FL2 - 4) begin
        if (!txd2) lows++;
      end else if (i < FL2) begin
        if (txd2) highs++;
      end
      if (i < FL2 && done2) d2early++;
      if (i == FL2 - 1) post("d2_busy_last", busy2, 1);
      if (i == FL2) begin
        post("d2_done", done2, 1);
        post("d2_ready", ready2, 1);
        post("d2_txd_idle", txd2, 1);
      end
    end
    post("d2_low", lows, FL2 - 4);
    post("d2_high", highs, 4);
    post("d2_done_early", d2early, 0);

    repeat (3) @(negedge clk);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
